// File: rtl/enemy_pkg.sv
// Shared encodings for the enemy sprite controller: FSM states, enemy kinds
// and sprite frame offsets relative to the configured base id.
package enemy_pkg;

   typedef enum logic [2:0] {
      ST_HIDDEN   = 3'd0,
      ST_WALK     = 3'd1,
      ST_SHELL    = 3'd2,
      ST_SLIDE    = 3'd3,
      ST_SQUASHED = 3'd4,
      ST_DEAD     = 3'd5
   } state_t;

   localparam int KIND_SQUASH = 0;
   localparam int KIND_SHELL  = 1;

   localparam int FRAME_WALK0 = 0;
   localparam int FRAME_WALK1 = 1;
   localparam int FRAME_FLAT  = 2;

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector. The first clock after reset only captures
// the level, so an input already high at reset release never fires.
module edge_pulse (
   input  logic clk,
   input  logic rstn,
   input  logic i_level,
   output logic o_pulse
);

   logic r_prev;
   logic r_armed;
   logic r_pulse;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_prev  <= 1'b0;
         r_armed <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_prev  <= i_level;
         r_armed <= 1'b1;
         r_pulse <= r_armed & i_level & ~r_prev;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/enemy_walker.sv
// Enemy sprite controller for shell-type and squash-type enemies: owns the
// behaviour FSM, horizontal position with bound clamping, and the state timer.
module enemy_walker
   import enemy_pkg::*;
#(
   parameter int KIND        = 1,
   parameter int POS_W       = 11,
   parameter int ID_W        = 6,
   parameter int ID_BASE     = 0,
   parameter int SPAWN_X     = 400,
   parameter int SPAWN_Y     = 300,
   parameter int X_MIN       = 0,
   parameter int X_MAX       = 1023,
   parameter int WALK_STEP   = 1,
   parameter int SLIDE_STEP  = 4,
   parameter int TIMER_W     = 24,
   parameter int SHELL_TIME  = 1000,
   parameter int SQUASH_TIME = 200
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             anim_tick,
   input  logic             initial_show,
   input  logic             collapsion_impulse,
   input  logic             press_impulse,
   input  logic             kick_dir,
   output logic [ID_W-1:0]  id,
   output logic             oriental,
   output logic [POS_W-1:0] w,
   output logic [POS_W-1:0] h,
   output logic             shell,
   output logic             shell_anim,
   output logic             alive
);

   localparam logic [ID_W-1:0]    L_ID_WALK0    = ID_W'(ID_BASE + FRAME_WALK0);
   localparam logic [ID_W-1:0]    L_ID_WALK1    = ID_W'(ID_BASE + FRAME_WALK1);
   localparam logic [ID_W-1:0]    L_ID_FLAT     = ID_W'(ID_BASE + FRAME_FLAT);
   localparam logic [TIMER_W-1:0] L_SHELL_LOAD  = TIMER_W'(SHELL_TIME - 1);
   localparam logic [TIMER_W-1:0] L_SQUASH_LOAD = TIMER_W'(SQUASH_TIME - 1);
   localparam logic [TIMER_W-1:0] L_WOBBLE      = TIMER_W'(SHELL_TIME / 4);

   // Returns {flip, position}; flip is set when the step hit a bound and was clamped.
   function automatic logic [POS_W:0] f_step(input logic [POS_W-1:0] pos,
                                             input logic dir, input int step);
      int p;
      p = dir ? int'(pos) + step : int'(pos) - step;
      if (p > X_MAX)      return {1'b1, POS_W'(X_MAX)};
      else if (p < X_MIN) return {1'b1, POS_W'(X_MIN)};
      else                return {1'b0, POS_W'(p)};
   endfunction

   logic w_press;
   logic w_coll;
   logic w_dir;
   logic w_flip;
   logic [POS_W-1:0] w_pos_nxt;

   state_t             r_state;
   logic [POS_W-1:0]   r_w;
   logic [POS_W-1:0]   r_h;
   logic               r_oriental;
   logic [ID_W-1:0]    r_id;
   logic               r_shell;
   logic               r_shell_anim;
   logic               r_alive;
   logic [TIMER_W-1:0] r_timer;

   edge_pulse u_press_edge (
      .clk     (clk),
      .rstn    (rstn),
      .i_level (press_impulse),
      .o_pulse (w_press)
   );

   edge_pulse u_coll_edge (
      .clk     (clk),
      .rstn    (rstn),
      .i_level (collapsion_impulse),
      .o_pulse (w_coll)
   );

   always_comb begin
      w_dir = r_oriental ^ w_coll;
      {w_flip, w_pos_nxt} = f_step(r_w, w_dir,
                                   (r_state == ST_SLIDE) ? SLIDE_STEP : WALK_STEP);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= ST_HIDDEN;
         r_w          <= POS_W'(SPAWN_X);
         r_h          <= POS_W'(SPAWN_Y);
         r_oriental   <= 1'b0;
         r_id         <= L_ID_WALK0;
         r_shell      <= 1'b0;
         r_shell_anim <= 1'b0;
         r_alive      <= 1'b0;
         r_timer      <= '0;
      end else begin
         case (r_state)
            ST_HIDDEN: begin
               if (initial_show) begin
                  r_state <= ST_WALK;
                  r_alive <= 1'b1;
               end
            end
            ST_WALK: begin
               if (w_press) begin
                  r_state <= (KIND == KIND_SHELL) ? ST_SHELL : ST_SQUASHED;
                  r_timer <= (KIND == KIND_SHELL) ? L_SHELL_LOAD : L_SQUASH_LOAD;
                  r_id    <= L_ID_FLAT;
                  r_shell <= (KIND == KIND_SHELL);
               end else if (anim_tick) begin
                  r_w        <= w_pos_nxt;
                  r_oriental <= w_dir ^ w_flip;
                  r_id       <= (r_id == L_ID_WALK0) ? L_ID_WALK1 : L_ID_WALK0;
               end else begin
                  r_oriental <= w_dir;
               end
            end
            ST_SHELL: begin
               if (w_press) begin
                  r_state      <= ST_SLIDE;
                  r_oriental   <= kick_dir;
                  r_shell_anim <= 1'b0;
               end else if (r_timer == '0) begin
                  r_state      <= ST_WALK;
                  r_shell      <= 1'b0;
                  r_shell_anim <= 1'b0;
                  r_id         <= L_ID_WALK0;
               end else begin
                  r_timer <= r_timer - 1'b1;
                  // Wobble only in the final quarter so the player sees the wake-up coming.
                  if (r_timer < L_WOBBLE) begin
                     if (anim_tick) r_shell_anim <= ~r_shell_anim;
                  end else begin
                     r_shell_anim <= 1'b0;
                  end
               end
            end
            ST_SLIDE: begin
               if (w_press) begin
                  r_state      <= ST_SHELL;
                  r_timer      <= L_SHELL_LOAD;
                  r_shell_anim <= 1'b0;
               end else if (anim_tick) begin
                  r_w        <= w_pos_nxt;
                  r_oriental <= w_dir ^ w_flip;
               end else begin
                  r_oriental <= w_dir;
               end
            end
            ST_SQUASHED: begin
               if (r_timer == '0) begin
                  r_state <= ST_DEAD;
                  r_alive <= 1'b0;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            ST_DEAD: begin
               r_alive <= 1'b0;
            end
            default: r_state <= ST_HIDDEN;
         endcase
      end
   end

   assign id         = r_id;
   assign oriental   = r_oriental;
   assign w          = r_w;
   assign h          = r_h;
   assign shell      = r_shell;
   assign shell_anim = r_shell_anim;
   assign alive      = r_alive;

endmodule
